// File: rtl/wheel_speed_meter.sv
// Tone-wheel speed meter: synchronizes and glitch-filters the sensor line, counts teeth per gate window.
// Optional median-of-three output smoothing is built when WHEEL_SPEED_METER_MEDIAN_EN is defined.
module wheel_speed_meter #(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned MIN_HIGH      = 2,
  parameter int unsigned STALL_WINDOWS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tone_pulse,
  output logic [7:0] wheel_speed,
  output logic       speed_valid,
  output logic       saturated,
  output logic       stalled
);

  typedef enum logic [1:0] {IDLE, MEASURE, PUBLISH} state_t;

  localparam logic [15:0] GATE_LAST = 16'(GATE_CYCLES - 1);
  localparam logic [4:0]  HIGH_HIT  = 5'(MIN_HIGH);
  localparam logic [4:0]  HIGH_MAX  = 5'(MIN_HIGH + 1);
  localparam logic [3:0]  STALL_TH  = 4'(STALL_WINDOWS);

  logic        sync1_q, sync2_q;
  logic [4:0]  high_cnt_q, high_cnt_d;
  logic        tooth;
  state_t      state_q, state_d;
  logic [15:0] gate_cnt_q, gate_cnt_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic [7:0]  pulse_inc;
  logic [3:0]  zero_cnt_q, zero_cnt_d;
  logic [7:0]  speed_q, speed_d;
  logic        valid_q, valid_d;
  logic        sat_q, sat_d;
  logic [7:0]  publish_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tone_pulse;
      sync2_q <= sync1_q;
    end
  end

  // The high counter parks one above MIN_HIGH so a long pulse yields a single tooth.
  always_comb begin
    high_cnt_d = high_cnt_q;
    if (!sync2_q) begin
      high_cnt_d = '0;
    end else if (high_cnt_q != HIGH_MAX) begin
      high_cnt_d = high_cnt_q + 5'd1;
    end
  end

  assign tooth     = (high_cnt_q == HIGH_HIT);
  assign pulse_inc = (tooth && (pulse_cnt_q != 8'hFF)) ? pulse_cnt_q + 8'd1 : pulse_cnt_q;

`ifdef WHEEL_SPEED_METER_MEDIAN_EN
  logic [7:0] hist1_q, hist2_q;

  function automatic logic [7:0] median3(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    logic ab, bc, ac;
    ab = (a >= b);
    bc = (b >= c);
    ac = (a >= c);
    if (ab == bc) begin
      return b;
    end else if (!ab) begin
      return ac ? a : c;
    end else begin
      return ac ? c : a;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (state_q == PUBLISH) begin
      hist1_q <= pulse_cnt_q;
      hist2_q <= hist1_q;
    end
  end

  assign publish_val = median3(pulse_cnt_q, hist1_q, hist2_q);
`else
  assign publish_val = pulse_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    speed_d     = speed_q;
    sat_d       = sat_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        gate_cnt_d  = '0;
        pulse_cnt_d = '0;
        if (enable) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d     = IDLE;
          gate_cnt_d  = '0;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_inc;
          if (gate_cnt_q == GATE_LAST) begin
            state_d = PUBLISH;
          end else begin
            gate_cnt_d = gate_cnt_q + 16'd1;
          end
        end
      end
      PUBLISH: begin
        valid_d    = 1'b1;
        speed_d    = publish_val;
        sat_d      = (pulse_cnt_q == 8'hFF);
        gate_cnt_d = '0;
        if (pulse_cnt_q == 8'd0) begin
          zero_cnt_d = (zero_cnt_q == 4'hF) ? 4'hF : zero_cnt_q + 4'd1;
        end else begin
          zero_cnt_d = '0;
        end
        // A tooth landing here belongs to the window that starts next cycle.
        pulse_cnt_d = (enable && tooth) ? 8'd1 : 8'd0;
        state_d     = enable ? MEASURE : IDLE;
      end
      default: begin
        state_d     = IDLE;
        gate_cnt_d  = '0;
        pulse_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      high_cnt_q  <= '0;
      gate_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      zero_cnt_q  <= '0;
      speed_q     <= '0;
      sat_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_cnt_q  <= high_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      speed_q     <= speed_d;
      sat_q       <= sat_d;
      valid_q     <= valid_d;
    end
  end

  assign wheel_speed = speed_q;
  assign speed_valid = valid_q;
  assign saturated   = sat_q;
  assign stalled     = (zero_cnt_q >= STALL_TH);

endmodule

// File: tb/tb_wheel_speed_meter.sv
// Scoreboard bench for wheel_speed_meter: a short-gate instance for timing scenarios and a
// long-gate instance for saturation and median-spike scenarios (counts above ~33 need a long window).
module tb_wheel_speed_meter;

  localparam int GATE   = 100;
  localparam int GATE_S = 1000;
  localparam int STALL  = 4;

  typedef struct packed {
    logic [7:0] speed;
    logic       sat;
    logic       stall;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       tone = 1'b0;
  logic       enable_s = 1'b0;
  logic       tone_s = 1'b0;
  logic [7:0] wheel_speed, ws_s;
  logic       speed_valid, sv_s, saturated, sat_s, stalled, st_s;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_at = 0;
  exp_t last_main = '0;
  exp_t q_main[$];
  exp_t q_sat[$];
  int   zc[2];
  int   h1[2];
  int   h2[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wheel_speed_meter #(.GATE_CYCLES(GATE), .MIN_HIGH(2), .STALL_WINDOWS(STALL)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .tone_pulse(tone),
    .wheel_speed(wheel_speed), .speed_valid(speed_valid), .saturated(saturated), .stalled(stalled)
  );

  wheel_speed_meter #(.GATE_CYCLES(GATE_S), .MIN_HIGH(2), .STALL_WINDOWS(STALL)) u_sat (
    .clk(clk), .reset(reset), .enable(enable_s), .tone_pulse(tone_s),
    .wheel_speed(ws_s), .speed_valid(sv_s), .saturated(sat_s), .stalled(st_s)
  );

  function automatic int med3(input int a, input int b, input int c);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  task automatic model_reset(input int which);
    zc[which] = 0;
    h1[which] = 0;
    h2[which] = 0;
  endtask

  // Expected publish for a window whose tooth count is raw; pushed before stimulus is driven.
  task automatic model_push(input int which, input int raw);
    exp_t e;
    int   r;
    r = (raw > 255) ? 255 : raw;
    zc[which] = (r == 0) ? ((zc[which] < 15) ? zc[which] + 1 : 15) : 0;
`ifdef WHEEL_SPEED_METER_MEDIAN_EN
    e.speed = 8'(med3(r, h1[which], h2[which]));
`else
    e.speed = 8'(r);
`endif
    h2[which] = h1[which];
    h1[which] = r;
    e.sat   = (r == 255);
    e.stall = (zc[which] >= STALL);
    if (which == 0) q_main.push_back(e);
    else q_sat.push_back(e);
  endtask

  task automatic drive_teeth(input int which, input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      if (which == 0) tone = 1'b1; else tone_s = 1'b1;
      repeat (hi) @(negedge clk);
      if (which == 0) tone = 1'b0; else tone_s = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // Bounded wait for the next speed_valid, then pop the matching expectation.
  task automatic next_publish(input int which, output bit got, output exp_t e, output int at);
    int limit;
    got   = 1'b0;
    at    = 0;
    limit = (which == 0) ? 2 * GATE : 2 * GATE_S;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (((which == 0) ? speed_valid : sv_s) === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
    e = 'x;
    if (which == 0) begin
      if (q_main.size() > 0) e = q_main.pop_front();
      last_main = e;
    end else if (q_sat.size() > 0) begin
      e = q_sat.pop_front();
    end
  endtask

  task automatic test_reset();
    bit   got;
    exp_t e;
    int   at, t0;
    repeat (3) @(negedge clk);
    checks++;
    if (wheel_speed !== 8'd0 || speed_valid !== 1'b0 || saturated !== 1'b0 || stalled !== 1'b0 ||
        ws_s !== 8'd0 || sv_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got speed=%0d valid=%0b sat=%0b stall=%0b, expected all 0",
               wheel_speed, speed_valid, saturated, stalled);
    end else $display("reset_state: all outputs 0");
    model_reset(0);
    model_reset(1);
    reset  = 1'b1;
    enable = 1'b1;
    t0 = cyc;
    model_push(0, 0);
    next_publish(0, got, e, at);
    checks++;
    if (!got || wheel_speed !== e.speed || saturated !== e.sat || stalled !== e.stall ||
        at - t0 != GATE + 2) begin
      failures++;
      $display("FAIL first_window: got valid=%0b speed=%0d sat=%0b stall=%0b latency=%0d, expected speed=%0d sat=%0b stall=%0b latency=%0d",
               got, wheel_speed, saturated, stalled, at - t0, e.speed, e.sat, e.stall, GATE + 2);
    end else $display("first_window: speed=%0d latency=%0d", wheel_speed, at - t0);
    last_at = at;
  endtask

  task automatic test_steady();
    bit   got;
    exp_t e;
    int   at;
    for (int w = 0; w < 3; w++) begin
      model_push(0, 10);
      drive_teeth(0, 10, 4, 4);
      next_publish(0, got, e, at);
      checks++;
      if (!got || wheel_speed !== e.speed || saturated !== e.sat || stalled !== e.stall ||
          at - last_at != GATE + 1) begin
        failures++;
        $display("FAIL steady_w%0d: got valid=%0b speed=%0d sat=%0b stall=%0b period=%0d, expected speed=%0d sat=%0b stall=%0b period=%0d",
                 w, got, wheel_speed, saturated, stalled, at - last_at, e.speed, e.sat, e.stall, GATE + 1);
      end else $display("steady_w%0d: speed=%0d period=%0d", w, wheel_speed, at - last_at);
      last_at = at;
    end
  endtask

  task automatic test_glitch();
    bit   got;
    exp_t e;
    int   at;
    for (int w = 0; w < 5; w++) begin
      model_push(0, (w == 4) ? 1 : 0);
      if (w == 4) drive_teeth(0, 1, 4, 4);
      else drive_teeth(0, 10, 1, 4);
      next_publish(0, got, e, at);
      checks++;
      if (!got || wheel_speed !== e.speed || saturated !== e.sat || stalled !== e.stall) begin
        failures++;
        $display("FAIL glitch_w%0d: got valid=%0b speed=%0d sat=%0b stall=%0b, expected speed=%0d sat=%0b stall=%0b",
                 w, got, wheel_speed, saturated, stalled, e.speed, e.sat, e.stall);
      end else $display("glitch_w%0d: speed=%0d stall=%0b", w, wheel_speed, stalled);
      last_at = at;
    end
  endtask

  // Tooth event lands 4 cycles after the rise: gate 99 in window 0, PUBLISH in window 1.
  task automatic test_boundaries();
    bit   got;
    exp_t e;
    int   at;
    for (int w = 0; w < 3; w++) begin
      model_push(0, (w == 1) ? 0 : 1);
      if (w < 2) begin
        repeat (95 + w) @(negedge clk);
        tone = 1'b1;
        repeat (2) @(negedge clk);
        tone = 1'b0;
      end
      next_publish(0, got, e, at);
      checks++;
      if (!got || wheel_speed !== e.speed || saturated !== e.sat || stalled !== e.stall ||
          at - last_at != GATE + 1) begin
        failures++;
        $display("FAIL boundary_w%0d: got valid=%0b speed=%0d sat=%0b stall=%0b period=%0d, expected speed=%0d sat=%0b stall=%0b period=%0d",
                 w, got, wheel_speed, saturated, stalled, at - last_at, e.speed, e.sat, e.stall, GATE + 1);
      end else $display("boundary_w%0d: speed=%0d", w, wheel_speed);
      last_at = at;
    end
  endtask

  task automatic test_interrupt();
    bit   got;
    exp_t e, held;
    int   at, t0, nvalid;
    held = last_main;
    drive_teeth(0, 3, 4, 4);
    repeat (26) @(negedge clk);
    enable = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (speed_valid !== 1'b0) nvalid++;
    end
    checks++;
    if (nvalid != 0 || wheel_speed !== held.speed || saturated !== held.sat || stalled !== held.stall) begin
      failures++;
      $display("FAIL enable_drop_hold: got valids=%0d speed=%0d sat=%0b stall=%0b, expected valids=0 speed=%0d sat=%0b stall=%0b",
               nvalid, wheel_speed, saturated, stalled, held.speed, held.sat, held.stall);
    end else $display("enable_drop_hold: no publish, speed held at %0d", wheel_speed);
    enable = 1'b1;
    t0 = cyc;
    model_push(0, 5);
    drive_teeth(0, 5, 4, 4);
    next_publish(0, got, e, at);
    checks++;
    if (!got || wheel_speed !== e.speed || stalled !== e.stall || at - t0 != GATE + 2) begin
      failures++;
      $display("FAIL enable_restart: got valid=%0b speed=%0d stall=%0b latency=%0d, expected speed=%0d stall=%0b latency=%0d",
               got, wheel_speed, stalled, at - t0, e.speed, e.stall, GATE + 2);
    end else $display("enable_restart: speed=%0d latency=%0d", wheel_speed, at - t0);
    drive_teeth(0, 3, 4, 4);
    repeat (26) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wheel_speed !== 8'd0 || speed_valid !== 1'b0 || saturated !== 1'b0 || stalled !== 1'b0) begin
      failures++;
      $display("FAIL midwindow_reset: got speed=%0d valid=%0b sat=%0b stall=%0b, expected all 0",
               wheel_speed, speed_valid, saturated, stalled);
    end else $display("midwindow_reset: outputs cleared");
    reset = 1'b1;
    model_reset(0);
    model_reset(1);
    t0 = cyc;
    model_push(0, 0);
    next_publish(0, got, e, at);
    checks++;
    if (!got || wheel_speed !== e.speed || stalled !== e.stall || at - t0 != GATE + 2) begin
      failures++;
      $display("FAIL reset_restart: got valid=%0b speed=%0d stall=%0b latency=%0d, expected speed=%0d stall=%0b latency=%0d",
               got, wheel_speed, stalled, at - t0, e.speed, e.stall, GATE + 2);
    end else $display("reset_restart: speed=%0d latency=%0d", wheel_speed, at - t0);
    enable = 1'b0;
  endtask

  task automatic test_saturation();
    bit   got;
    exp_t e;
    int   at;
    int   raws[3] = '{0, 300, 20};
    enable_s = 1'b1;
    for (int w = 0; w < 3; w++) begin
      model_push(1, raws[w]);
      drive_teeth(1, raws[w], 2, 1);
      next_publish(1, got, e, at);
      checks++;
      if (!got || ws_s !== e.speed || sat_s !== e.sat || st_s !== e.stall) begin
        failures++;
        $display("FAIL saturation_w%0d: got valid=%0b speed=%0d sat=%0b stall=%0b, expected speed=%0d sat=%0b stall=%0b",
                 w, got, ws_s, sat_s, st_s, e.speed, e.sat, e.stall);
      end else $display("saturation_w%0d: teeth=%0d speed=%0d sat=%0b", w, raws[w], ws_s, sat_s);
    end
  endtask

  task automatic test_median_spike();
    bit   got;
    exp_t e;
    int   at;
    int   raws[3] = '{10, 200, 12};
    for (int w = 0; w < 3; w++) begin
      model_push(1, raws[w]);
      drive_teeth(1, raws[w], 2, 1);
      next_publish(1, got, e, at);
      checks++;
      if (!got || ws_s !== e.speed || sat_s !== e.sat || st_s !== e.stall) begin
        failures++;
        $display("FAIL spike_w%0d: got valid=%0b speed=%0d sat=%0b stall=%0b, expected speed=%0d sat=%0b stall=%0b",
                 w, got, ws_s, sat_s, st_s, e.speed, e.sat, e.stall);
      end else $display("spike_w%0d: teeth=%0d speed=%0d", w, raws[w], ws_s);
    end
    checks++;
    if (ws_s !== 8'd12) begin
      failures++;
      $display("FAIL spike_final: got speed=%0d, expected 12", ws_s);
    end else $display("spike_final: speed=12");
    enable_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_boundaries();
    test_interrupt();
    test_saturation();
    test_median_spike();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
